// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller with HI/LO ownership for the E-stage ALU.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) enabled by defining MD_UNIT_MADD_EN.
//
// state | meaning
// IDLE  | no mult/div in flight; mthi/mtlo and new long ops accepted
// RUN   | latency counter running; result written to HI/LO when it reaches 0
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        pending,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   op_a;
  logic [31:0]   op_b;

  logic          long_op;
  logic [CW-1:0] lat;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   quo_s;
  logic [31:0]   rem_s;
  logic [31:0]   quo_u;
  logic [31:0]   rem_u;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  always_comb begin
    long_op = 1'b0;
    lat     = CW'(MULT_CYCLES);
    case (mdop)
      OP_MULT, OP_MULTU: long_op = 1'b1;
      OP_DIV, OP_DIVU: begin
        long_op = 1'b1;
        lat     = CW'(DIV_CYCLES);
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: long_op = 1'b1;
`endif
      default: long_op = 1'b0;
    endcase
  end

  assign pending = busy | (start & long_op);

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};
  assign quo_s  = (op_b != 32'd0) ? $unsigned($signed(op_a) / $signed(op_b)) : 32'd0;
  assign rem_s  = (op_b != 32'd0) ? $unsigned($signed(op_a) % $signed(op_b)) : 32'd0;
  assign quo_u  = (op_b != 32'd0) ? op_a / op_b : 32'd0;
  assign rem_u  = (op_b != 32'd0) ? op_a % op_b : 32'd0;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: if (op_b != 32'd0) begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      OP_DIVU: if (op_b != 32'd0) begin
        res_hi = rem_u;
        res_lo = quo_u;
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
      default: begin
        res_hi = hi;
        res_lo = lo;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= 4'd0;
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (long_op) begin
              op_q  <= mdop;
              op_a  <= a;
              op_b  <= b;
              cnt   <= lat;
              busy  <= 1'b1;
              state <= RUN;
            end else if (mdop == OP_MTHI) begin
              hi <= a;
            end else if (mdop == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            hi    <= res_hi;
            lo    <= res_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed-vector bench for md_unit_ctrl; madd/msub vectors run when MD_UNIT_MADD_EN is defined.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        pending;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .a(a), .b(b), .busy(busy), .pending(pending), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one start cycle at a negedge; returns at the negedge after the accepting edge
  // with operands scrambled so late operand changes would show up in results.
  task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    a     = 32'hA5A5_5A5A;
    b     = 32'h0000_0003;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic long_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input int cycles,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    a     = va;
    b     = vb;
    #1 check({tag, "_pending"}, {31'd0, pending}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    a     = 32'hA5A5_5A5A;
    b     = 32'h0000_0003;
    count_busy(n);
    check({tag, "_cycles"}, n, cycles);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    mdop  = 4'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_pending", {31'd0, pending}, 32'd0);

    long_op("mult",   4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    long_op("multu",  4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5,  32'h0000_0001, 32'hFFFF_FFFE);
    long_op("mult_mm",4'd1, 32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000);
    long_op("div_n",  4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    long_op("div_dn", 4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    long_op("divu",   4'd4, 32'h0000_0007, 32'h0000_0002, 10, 32'h0000_0001, 32'h0000_0003);

    // mthi is single-cycle and never raises busy
    @(negedge clk);
    start = 1'b1;
    mdop  = 4'd5;
    a     = 32'h1234_5678;
    #1 check("mthi_pending", {31'd0, pending}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h0000_0003);

    // divide by zero keeps HI/LO; starts during busy are dropped
    issue(4'd4, 32'd5, 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    mdop  = 4'd1;
    a     = 32'h0000_0009;
    b     = 32'h0000_0009;
    @(negedge clk);
    mdop  = 4'd5;
    a     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    check("busy_mthi_hi", hi, 32'h1234_5678);
    count_busy(n);
    check("divz_cycles", n + 4, 10);
    check("divz_hi", hi, 32'h1234_5678);
    check("divz_lo", lo, 32'h0000_0003);
    repeat (6) @(negedge clk);
    check("ignored_busy", {31'd0, busy}, 32'd0);
    check("ignored_hi", hi, 32'h1234_5678);
    check("ignored_lo", lo, 32'h0000_0003);

    // illegal opcode 15 has no effect
    issue(4'd15, 32'h0000_0055, 32'h0000_0011);
    check("illegal_busy", {31'd0, busy}, 32'd0);
    check("illegal_hi", hi, 32'h1234_5678);

`ifdef MD_UNIT_MADD_EN
    issue(4'd6, 32'd10, 32'd0);
    issue(4'd5, 32'd0, 32'd0);
    long_op("madd",  4'd7,  32'd3, 32'd4,  5, 32'h0000_0000, 32'h0000_0016);
    long_op("msubu", 4'd10, 32'd1, 32'd23, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd5, 32'h1234_5678, 32'd0);
    issue(4'd6, 32'h0000_0003, 32'd0);
`else
    @(negedge clk);
    start = 1'b1;
    mdop  = 4'd7;
    a     = 32'd3;
    b     = 32'd4;
    #1 check("madd_off_pending", {31'd0, pending}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    mdop  = 4'd0;
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("madd_off_lo", lo, 32'h0000_0003);
`endif

    // reset on busy cycle 4 aborts the divide with no later write
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
